// File: rtl/roce_rx_ip_filter_pkg.sv
// Shared constants, FSM state type and header geometry helper for the RoCEv2 RX IP filter.
package roce_rx_ip_filter_pkg;

  localparam logic [15:0] ROCE_UDP_PORT_DEFAULT = 16'd4791;
  localparam logic [7:0]  IPV4_PROTO_UDP        = 8'd17;
  localparam logic [3:0]  IPV4_VERSION          = 4'd4;
  localparam int unsigned IPV4_HDR_BYTES        = 20;
  localparam int unsigned IPV4_PROTO_OFFSET     = 9;
  localparam int unsigned IPV4_DST_OFFSET       = 16;
  localparam int unsigned UDP_DPORT_OFFSET      = 22;
  localparam int unsigned HDR_BYTES             = 24;
  localparam int unsigned BEAT_IDX_W            = 2;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_EMIT,
    ST_PASS,
    ST_DROP
  } filt_state_e;

  // Beats needed to hold the 24-byte IPv4+UDP header prefix.
  function automatic int unsigned hdr_beats(input int unsigned width);
    return (width >= 32'd512) ? 32'd1 : 32'd3;
  endfunction

endpackage

// File: rtl/roce_rx_hdr_check.sv
// Combinational RoCEv2 accept and runt decision over the assembled header prefix.
module roce_rx_hdr_check
  import roce_rx_ip_filter_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned HDR_BEATS     = hdr_beats(WIDTH),
  parameter logic [15:0] ROCE_UDP_PORT = ROCE_UDP_PORT_DEFAULT
) (
  input  logic [HDR_BEATS*WIDTH-1:0] hdr_flat_i,
  input  logic [WIDTH/8-1:0]         cur_keep_i,
  input  logic                       cur_last_i,
  input  logic [BEAT_IDX_W-1:0]      beat_idx_i,
  input  logic [31:0]                local_ip_i,
  output logic                       accept_c,
  output logic                       runt_c
);

  localparam int unsigned KEEP_W    = WIDTH / 8;
  localparam int unsigned LAST_LANE = (HDR_BYTES - 1) % KEEP_W;
  localparam logic [BEAT_IDX_W-1:0] FINAL_IDX = BEAT_IDX_W'(HDR_BEATS - 1);

  logic [7:0]  ver_ihl;
  logic [7:0]  proto;
  logic [31:0] dst_ip;
  logic [15:0] dport;
  logic        unused_ok;

  // Byte n lives at bit n*8 of the flattened beats, so fields index directly.
  assign ver_ihl = hdr_flat_i[0 +: 8];
  assign proto   = hdr_flat_i[IPV4_PROTO_OFFSET*8 +: 8];
  assign dst_ip  = hdr_flat_i[IPV4_DST_OFFSET*8 +: 32];
  assign dport   = {hdr_flat_i[UDP_DPORT_OFFSET*8 +: 8], hdr_flat_i[(UDP_DPORT_OFFSET+1)*8 +: 8]};

  assign accept_c = (ver_ihl[7:4] == IPV4_VERSION) &&
                    (ver_ihl[3:0] == 4'(IPV4_HDR_BYTES / 4)) &&
                    (proto == IPV4_PROTO_UDP) &&
                    (dst_ip == local_ip_i) &&
                    (dport == ROCE_UDP_PORT);

  assign runt_c = cur_last_i && ((beat_idx_i != FINAL_IDX) || !cur_keep_i[LAST_LANE]);

  assign unused_ok = ^{hdr_flat_i, cur_keep_i};

endmodule

// File: rtl/roce_rx_ip_filter.sv
// Forwards only RoCEv2 packets addressed to this node; drops everything else whole and counts drops.
module roce_rx_ip_filter
  import roce_rx_ip_filter_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter logic [15:0] ROCE_UDP_PORT = ROCE_UDP_PORT_DEFAULT
) (
  input  logic               net_clk,
  input  logic               net_rst,
  input  logic               s_axis_rx_data_tvalid,
  output logic               s_axis_rx_data_tready,
  input  logic [WIDTH-1:0]   s_axis_rx_data_tdata,
  input  logic [WIDTH/8-1:0] s_axis_rx_data_tkeep,
  input  logic               s_axis_rx_data_tlast,
  output logic               m_axis_rx_data_tvalid,
  input  logic               m_axis_rx_data_tready,
  output logic [WIDTH-1:0]   m_axis_rx_data_tdata,
  output logic [WIDTH/8-1:0] m_axis_rx_data_tkeep,
  output logic               m_axis_rx_data_tlast,
  input  logic [31:0]        local_ip_address,
  output logic [31:0]        filter_drop_count_data,
  output logic               filter_drop_count_valid,
  output logic [31:0]        runt_drop_count_data,
  output logic               runt_drop_count_valid
);

  localparam int unsigned KEEP_W    = WIDTH / 8;
  localparam int unsigned HDR_BEATS = hdr_beats(WIDTH);
  localparam logic [BEAT_IDX_W-1:0] FINAL_IDX = BEAT_IDX_W'(HDR_BEATS - 1);

  filt_state_e             state_q, state_d;
  logic [BEAT_IDX_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [BEAT_IDX_W-1:0]   emit_idx_q, emit_idx_d;
  logic [WIDTH-1:0]        hdr_data_q [HDR_BEATS];
  logic [WIDTH-1:0]        hdr_data_d [HDR_BEATS];
  logic [KEEP_W-1:0]       hdr_keep_q [HDR_BEATS];
  logic [KEEP_W-1:0]       hdr_keep_d [HDR_BEATS];
  logic [HDR_BEATS-1:0]    hdr_last_q, hdr_last_d;
  logic                    m_valid_q, m_valid_d;
  logic [WIDTH-1:0]        m_data_q, m_data_d;
  logic [KEEP_W-1:0]       m_keep_q, m_keep_d;
  logic                    m_last_q, m_last_d;
  logic [31:0]             filt_cnt_q, filt_cnt_d;
  logic                    filt_vld_q, filt_vld_d;
  logic [31:0]             runt_cnt_q, runt_cnt_d;
  logic                    runt_vld_q, runt_vld_d;

  logic [HDR_BEATS*WIDTH-1:0] hdr_flat_c;
  logic [WIDTH-1:0]           emit_data_c;
  logic [KEEP_W-1:0]          emit_keep_c;
  logic                       emit_last_c;
  logic                       accept_c;
  logic                       runt_c;
  logic                       out_free_c;
  logic                       s_ready_c;

  // Earlier header beats come from the buffer, the final one from the live input.
  always_comb begin
    hdr_flat_c = '0;
    for (int i = 0; i < int'(HDR_BEATS) - 1; i++) begin
      hdr_flat_c[i*WIDTH +: WIDTH] = hdr_data_q[i];
    end
    hdr_flat_c[(HDR_BEATS-1)*WIDTH +: WIDTH] = s_axis_rx_data_tdata;
  end

  always_comb begin
    emit_data_c = hdr_data_q[0];
    emit_keep_c = hdr_keep_q[0];
    emit_last_c = hdr_last_q[0];
    for (int i = 1; i < int'(HDR_BEATS); i++) begin
      if (emit_idx_q == BEAT_IDX_W'(i)) begin
        emit_data_c = hdr_data_q[i];
        emit_keep_c = hdr_keep_q[i];
        emit_last_c = hdr_last_q[i];
      end
    end
  end

  roce_rx_hdr_check #(
    .WIDTH         (WIDTH),
    .HDR_BEATS     (HDR_BEATS),
    .ROCE_UDP_PORT (ROCE_UDP_PORT)
  ) u_hdr_check (
    .hdr_flat_i (hdr_flat_c),
    .cur_keep_i (s_axis_rx_data_tkeep),
    .cur_last_i (s_axis_rx_data_tlast),
    .beat_idx_i (hdr_cnt_q),
    .local_ip_i (local_ip_address),
    .accept_c   (accept_c),
    .runt_c     (runt_c)
  );

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    emit_idx_d = emit_idx_q;
    hdr_data_d = hdr_data_q;
    hdr_keep_d = hdr_keep_q;
    hdr_last_d = hdr_last_q;
    m_valid_d  = m_valid_q && !m_axis_rx_data_tready;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    filt_cnt_d = filt_cnt_q;
    filt_vld_d = 1'b0;
    runt_cnt_d = runt_cnt_q;
    runt_vld_d = 1'b0;
    out_free_c = !m_valid_q || m_axis_rx_data_tready;
    s_ready_c  = 1'b0;

    unique case (state_q)
      ST_HDR: begin
        s_ready_c = 1'b1;
        if (s_axis_rx_data_tvalid) begin
          for (int i = 0; i < int'(HDR_BEATS); i++) begin
            if (hdr_cnt_q == BEAT_IDX_W'(i)) begin
              hdr_data_d[i] = s_axis_rx_data_tdata;
              hdr_keep_d[i] = s_axis_rx_data_tkeep;
              hdr_last_d[i] = s_axis_rx_data_tlast;
            end
          end
          if (runt_c) begin
            hdr_cnt_d  = '0;
            runt_cnt_d = runt_cnt_q + 32'd1;
            runt_vld_d = 1'b1;
          end else if (hdr_cnt_q == FINAL_IDX) begin
            hdr_cnt_d = '0;
            if (accept_c) begin
              // Load the first header beat right away when the output register is free.
              if (out_free_c) begin
                m_valid_d = 1'b1;
                m_data_d  = hdr_data_d[0];
                m_keep_d  = hdr_keep_d[0];
                m_last_d  = hdr_last_d[0];
                if (HDR_BEATS == 1) begin
                  state_d = hdr_last_d[0] ? ST_HDR : ST_PASS;
                end else begin
                  state_d    = ST_EMIT;
                  emit_idx_d = BEAT_IDX_W'(1);
                end
              end else begin
                state_d    = ST_EMIT;
                emit_idx_d = '0;
              end
            end else begin
              filt_cnt_d = filt_cnt_q + 32'd1;
              filt_vld_d = 1'b1;
              state_d    = s_axis_rx_data_tlast ? ST_HDR : ST_DROP;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + BEAT_IDX_W'(1);
          end
        end
      end
      ST_EMIT: begin
        if (out_free_c) begin
          m_valid_d = 1'b1;
          m_data_d  = emit_data_c;
          m_keep_d  = emit_keep_c;
          m_last_d  = emit_last_c;
          if (emit_idx_q == FINAL_IDX) begin
            state_d = emit_last_c ? ST_HDR : ST_PASS;
          end else begin
            emit_idx_d = emit_idx_q + BEAT_IDX_W'(1);
          end
        end
      end
      ST_PASS: begin
        s_ready_c = out_free_c;
        if (s_axis_rx_data_tvalid && out_free_c) begin
          m_valid_d = 1'b1;
          m_data_d  = s_axis_rx_data_tdata;
          m_keep_d  = s_axis_rx_data_tkeep;
          m_last_d  = s_axis_rx_data_tlast;
          if (s_axis_rx_data_tlast) begin
            state_d = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        s_ready_c = 1'b1;
        if (s_axis_rx_data_tvalid && s_axis_rx_data_tlast) begin
          state_d = ST_HDR;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      state_q    <= ST_HDR;
      hdr_cnt_q  <= '0;
      emit_idx_q <= '0;
      for (int i = 0; i < int'(HDR_BEATS); i++) begin
        hdr_data_q[i] <= '0;
        hdr_keep_q[i] <= '0;
      end
      hdr_last_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      filt_cnt_q <= '0;
      filt_vld_q <= 1'b0;
      runt_cnt_q <= '0;
      runt_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      emit_idx_q <= emit_idx_d;
      hdr_data_q <= hdr_data_d;
      hdr_keep_q <= hdr_keep_d;
      hdr_last_q <= hdr_last_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      filt_cnt_q <= filt_cnt_d;
      filt_vld_q <= filt_vld_d;
      runt_cnt_q <= runt_cnt_d;
      runt_vld_q <= runt_vld_d;
    end
  end

  assign s_axis_rx_data_tready   = s_ready_c && !net_rst;
  assign m_axis_rx_data_tvalid   = m_valid_q;
  assign m_axis_rx_data_tdata    = m_data_q;
  assign m_axis_rx_data_tkeep    = m_keep_q;
  assign m_axis_rx_data_tlast    = m_last_q;
  assign filter_drop_count_data  = filt_cnt_q;
  assign filter_drop_count_valid = filt_vld_q;
  assign runt_drop_count_data    = runt_cnt_q;
  assign runt_drop_count_valid   = runt_vld_q;

endmodule

// File: tb/tb_roce_rx_ip_filter.sv
// Scoreboard bench for roce_rx_ip_filter at WIDTH=64 and WIDTH=512.
module tb_roce_rx_ip_filter;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  localparam logic [31:0] LOCAL_IP = 32'h0500_010A;  // 10.1.0.5, byte 0 in [7:0]

  logic clk;
  logic rst64, rst512;
  logic s64_valid, s64_ready, s64_last, m64_valid, m64_ready, m64_last;
  logic [63:0] s64_data, m64_data;
  logic [7:0]  s64_keep, m64_keep;
  logic s512_valid, s512_ready, s512_last, m512_valid, m512_ready, m512_last;
  logic [511:0] s512_data, m512_data;
  logic [63:0]  s512_keep, m512_keep;
  logic [31:0] fcnt64, rcnt64, fcnt512, rcnt512;
  logic fvld64, rvld64, fvld512, rvld512;

  int n_checks = 0;
  int n_errors = 0;
  beat_t exp64[$];
  beat_t exp512[$];
  logic [7:0] pkt_bytes[$];
  int fpulse64 = 0, rpulse64 = 0, fpulse512 = 0, rpulse512 = 0;
  int filt_model64 = 0, runt_model64 = 0;
  bit toggle64 = 0;
  bit stall64 = 0, stall512 = 0;
  logic [511:0] hold64, hold512;

  roce_rx_ip_filter #(.WIDTH(64)) u_dut64 (
    .net_clk(clk), .net_rst(rst64),
    .s_axis_rx_data_tvalid(s64_valid), .s_axis_rx_data_tready(s64_ready),
    .s_axis_rx_data_tdata(s64_data), .s_axis_rx_data_tkeep(s64_keep), .s_axis_rx_data_tlast(s64_last),
    .m_axis_rx_data_tvalid(m64_valid), .m_axis_rx_data_tready(m64_ready),
    .m_axis_rx_data_tdata(m64_data), .m_axis_rx_data_tkeep(m64_keep), .m_axis_rx_data_tlast(m64_last),
    .local_ip_address(LOCAL_IP),
    .filter_drop_count_data(fcnt64), .filter_drop_count_valid(fvld64),
    .runt_drop_count_data(rcnt64), .runt_drop_count_valid(rvld64)
  );

  roce_rx_ip_filter #(.WIDTH(512)) u_dut512 (
    .net_clk(clk), .net_rst(rst512),
    .s_axis_rx_data_tvalid(s512_valid), .s_axis_rx_data_tready(s512_ready),
    .s_axis_rx_data_tdata(s512_data), .s_axis_rx_data_tkeep(s512_keep), .s_axis_rx_data_tlast(s512_last),
    .m_axis_rx_data_tvalid(m512_valid), .m_axis_rx_data_tready(m512_ready),
    .m_axis_rx_data_tdata(m512_data), .m_axis_rx_data_tkeep(m512_keep), .m_axis_rx_data_tlast(m512_last),
    .local_ip_address(LOCAL_IP),
    .filter_drop_count_data(fcnt512), .filter_drop_count_valid(fvld512),
    .runt_drop_count_data(rcnt512), .runt_drop_count_valid(rvld512)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: pop the scoreboard on each handshake and check stall stability.
  always @(negedge clk) begin
    if (rst64) begin
      stall64 = 1'b0;
    end else begin
      if (stall64) begin
        chk("m64_hold_valid", m64_valid, 1'b1);
        chk("m64_hold_data", {m64_last, m64_data}, hold64);
      end
      if (m64_valid && m64_ready) begin
        if (exp64.size() == 0) begin
          chk("m64_spurious_beat", m64_valid, 1'b0);
        end else begin
          beat_t e;
          e = exp64.pop_front();
          chk("m64_data", m64_data, e.d);
          chk("m64_keep", m64_keep, e.k);
          chk("m64_last", m64_last, e.l);
        end
      end
      stall64 = m64_valid && !m64_ready;
      hold64  = {m64_last, m64_data};
      if (fvld64) fpulse64++;
      if (rvld64) rpulse64++;
    end
  end

  always @(negedge clk) begin
    if (rst512) begin
      stall512 = 1'b0;
    end else begin
      if (stall512) begin
        chk("m512_hold_valid", m512_valid, 1'b1);
        chk("m512_hold_data", m512_data, hold512);
      end
      if (m512_valid && m512_ready) begin
        if (exp512.size() == 0) begin
          chk("m512_spurious_beat", m512_valid, 1'b0);
        end else begin
          beat_t e;
          e = exp512.pop_front();
          chk("m512_data", m512_data, e.d);
          chk("m512_keep", m512_keep, e.k);
          chk("m512_last", m512_last, e.l);
        end
      end
      stall512 = m512_valid && !m512_ready;
      hold512  = m512_data;
      if (fvld512) fpulse512++;
      if (rvld512) rpulse512++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle64) m64_ready = !m64_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic make_pkt(input logic [31:0] dst, input logic [7:0] proto, input logic [3:0] ihl,
                          input logic [15:0] port, input int len);
    pkt_bytes.delete();
    for (int i = 0; i < len; i++) pkt_bytes.push_back(8'($urandom));
    if (len > 0)  pkt_bytes[0] = {4'h4, ihl};
    if (len > 9)  pkt_bytes[9] = proto;
    for (int i = 0; i < 4; i++) if (len > 16 + i) pkt_bytes[16+i] = dst[i*8 +: 8];
    if (len > 22) pkt_bytes[22] = port[15:8];
    if (len > 23) pkt_bytes[23] = port[7:0];
  endtask

  task automatic drive_beat(input bit sel, input logic [511:0] d, input logic [63:0] k, input bit l);
    bit ok;
    if (sel) begin
      s512_valid = 1'b1; s512_data = d; s512_keep = k; s512_last = l;
    end else begin
      s64_valid = 1'b1; s64_data = d[63:0]; s64_keep = k[7:0]; s64_last = l;
    end
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = sel ? s512_ready : s64_ready;
      @(posedge clk);
      #1;
    end
    if (sel) s512_valid = 1'b0; else s64_valid = 1'b0;
    if (!ok) begin
      if (sel) chk("s512_accept_timeout", ok, 1'b1);
      else chk("s64_accept_timeout", ok, 1'b1);
    end
  endtask

  task automatic send_pkt(input bit sel, input bit pass, input int max_beats);
    int bw, nb;
    logic [511:0] d;
    logic [63:0] k;
    beat_t e;
    bw = sel ? 64 : 8;
    nb = (pkt_bytes.size() + bw - 1) / bw;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      d = '0;
      k = '0;
      for (int l = 0; l < bw; l++) begin
        if (b * bw + l < pkt_bytes.size()) begin
          d[l*8 +: 8] = pkt_bytes[b*bw+l];
          k[l] = 1'b1;
        end
      end
      e.d = d; e.k = k; e.l = (b == nb - 1);
      if (pass) begin
        if (sel) exp512.push_back(e); else exp64.push_back(e);
      end
      drive_beat(sel, d, k, e.l);
      if (!sel && pass && b == 2 && nb > 3) begin
        @(negedge clk);
        chk("s64_ready_in_emit", s64_ready, 1'b0);
      end
    end
  endtask

  task automatic wait_drain(input bit sel);
    int left;
    left = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2;
      left = sel ? exp512.size() : exp64.size();
      if (left == 0 && !(sel ? m512_valid : m64_valid)) break;
    end
    if (sel) chk("m512_drain_left", left, 0); else chk("m64_drain_left", left, 0);
  endtask

  initial begin
    rst64 = 1'b1; rst512 = 1'b1;
    s64_valid = 1'b0; s64_data = '0; s64_keep = '0; s64_last = 1'b0; m64_ready = 1'b1;
    s512_valid = 1'b0; s512_data = '0; s512_keep = '0; s512_last = 1'b0; m512_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst64_m_valid", m64_valid, 1'b0);
    chk("rst64_s_ready", s64_ready, 1'b0);
    chk("rst64_filt_cnt", fcnt64, 32'd0);
    chk("rst64_runt_cnt", rcnt64, 32'd0);
    chk("rst512_m_valid", m512_valid, 1'b0);
    chk("rst512_s_ready", s512_ready, 1'b0);
    @(posedge clk);
    #1;
    rst64 = 1'b0; rst512 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 512-bit single-beat 48-byte RoCE packet: out one cycle later with last.
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 48);
    send_pkt(1'b1, 1'b1, 100);
    @(negedge clk);
    chk("m512_first_beat_latency", m512_valid, 1'b1);
    wait_drain(1'b1);

    // 64-bit 10-beat RoCE packet with output ready toggling.
    toggle64 = 1'b1;
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 80);
    send_pkt(1'b0, 1'b1, 100);
    wait_drain(1'b0);
    toggle64 = 1'b0;
    @(posedge clk);
    #2;
    m64_ready = 1'b1;

    // Wrong UDP port, then a good packet.
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4792, 48);
    send_pkt(1'b0, 1'b0, 100);
    filt_model64++;
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 40);
    send_pkt(1'b0, 1'b1, 100);
    wait_drain(1'b0);
    chk("filt64_after_port", fcnt64, 32'(filt_model64));
    chk("filt64_pulses_after_port", fpulse64, filt_model64);

    // Runts: last on beat 1, and a 23-byte packet missing header byte 23.
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 16);
    send_pkt(1'b0, 1'b0, 100);
    runt_model64++;
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 23);
    send_pkt(1'b0, 1'b0, 100);
    runt_model64++;
    repeat (3) @(posedge clk);
    #2;
    chk("runt64_count", rcnt64, 32'(runt_model64));
    chk("runt64_pulses", rpulse64, runt_model64);

    // Wrong destination, wrong protocol, wrong IHL.
    make_pkt(32'h0600_010A, 8'd17, 4'd5, 16'd4791, 32);
    send_pkt(1'b0, 1'b0, 100);
    make_pkt(LOCAL_IP, 8'd6, 4'd5, 16'd4791, 32);
    send_pkt(1'b0, 1'b0, 100);
    make_pkt(LOCAL_IP, 8'd17, 4'd6, 16'd4791, 32);
    send_pkt(1'b0, 1'b0, 100);
    filt_model64 += 3;
    // Header ending exactly at last.
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 24);
    send_pkt(1'b0, 1'b1, 100);
    wait_drain(1'b0);
    chk("filt64_final", fcnt64, 32'(filt_model64));
    chk("filt64_pulses_final", fpulse64, filt_model64);
    chk("runt64_final", rcnt64, 32'(runt_model64));

    // 512-bit back-to-back packets, including a 24-byte single-beat one.
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 150);
    send_pkt(1'b1, 1'b1, 100);
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 150);
    send_pkt(1'b1, 1'b1, 100);
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 24);
    send_pkt(1'b1, 1'b1, 100);
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 64);
    send_pkt(1'b1, 1'b1, 100);
    wait_drain(1'b1);

    // Reset in the middle of PASS.
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 300);
    send_pkt(1'b1, 1'b1, 2);
    rst512 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("m512_valid_after_reset", m512_valid, 1'b0);
    chk("s512_ready_in_reset", s512_ready, 1'b0);
    exp512.delete();
    @(posedge clk);
    #1;
    rst512 = 1'b0;
    make_pkt(LOCAL_IP, 8'd17, 4'd5, 16'd4791, 100);
    send_pkt(1'b1, 1'b1, 100);
    wait_drain(1'b1);
    chk("filt512_count", fcnt512, 32'd0);
    chk("runt512_count", rcnt512, 32'd0);
    chk("filt512_pulses", fpulse512, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/roce_rx_ip_filter.md
Name: roce_rx_ip_filter

Overview:
- Sits directly upstream of the RoCE stack RX input, between the IPv4 RX path and s_axis_rx_data.
- Inspects each IPv4 packet's IP and UDP header and forwards only RoCEv2 packets addressed to this node.
- A RoCEv2 packet here is: IPv4, IHL=5, UDP, destination IP = local address, UDP destination port 4791.
- Every other packet, and every runt, is discarded whole; dropped packets are counted.

Parameters:
- WIDTH, 64, stream data width in bits; only 64 and 512 are legal.
- ROCE_UDP_PORT, 16'd4791, UDP destination port accepted.

Ports:
- net_clk  in  1  clock.
- net_rst  in  1  synchronous, active-high reset.
- s_axis_rx_data  axi_stream.slave  WIDTH  IPv4 packet input (valid, ready, data, keep[WIDTH/8], last).
- m_axis_rx_data  axi_stream.master  WIDTH  filtered output toward the RoCE stack.
- local_ip_address  in  32  local IPv4 address, network order, byte 0 in [7:0]; sampled at each header decision.
- filter_drop_count_data  out  32  count of well-formed packets rejected by the header checks.
- filter_drop_count_valid  out  1  one-cycle pulse when filter_drop_count_data changes.
- runt_drop_count_data  out  32  count of packets ending before header byte 23.
- runt_drop_count_valid  out  1  one-cycle pulse when runt_drop_count_data changes.

Behaviour:
- Byte lane and header geometry:
  - Byte n of a packet is in lane n mod (WIDTH/8) of beat n div (WIDTH/8).
  - HDR_BEATS = 3 for WIDTH=64, 1 for WIDTH=512; the header is bytes 0..23.
- Header fields:
  - version = byte0[7:4]; IHL = byte0[3:0]; protocol = byte9.
  - dst IP = bytes16..19, compared with local_ip_address[7:0]..[31:24] in byte order.
  - UDP dst port = {byte22, byte23}.
- Accept condition: version==4 AND IHL==5 AND protocol==17 AND dst IP match AND port==ROCE_UDP_PORT.
- Reset values: m valid=0; both counters=0; both count valids=0; state=HDR; header buffer empty; s ready=0 during reset.
- State HDR (collect header beats):
  - s ready=1.
  - Each accepted beat is stored into header buffer slot k (HDR_BEATS entries, each holding data, keep, last).
  - Runt: last on beat k<HDR_BEATS-1, or on beat HDR_BEATS-1 with keep lane (23 mod WIDTH/8) = 0.
    - runt_drop_count +1 (wrapping) with its valid pulse next cycle.
    - Buffer cleared; stay in HDR.
  - On storing beat HDR_BEATS-1 (not a runt), the accept condition is evaluated on that cycle's data.
    - Pass -> EMIT.
    - Fail, beat not last -> DROP; filter_drop_count +1 with pulse.
    - Fail, beat last -> stay in HDR; filter_drop_count +1 with pulse.
- State EMIT (drain buffered header beats):
  - s ready=0.
  - Presents buffered beats in order on the output register; a beat advances on m valid AND m ready.
  - After the last buffered beat is taken: if that beat had last -> HDR, else -> PASS.
- State PASS (stream the payload):
  - Single output register; s ready = !m valid OR m ready.
  - Input beats are copied unchanged.
  - When the beat with last is accepted from the input -> HDR; the output register keeps draining.
  - The next packet's header beats may be collected while that final beat is still pending.
- State DROP (discard the rest of a rejected packet):
  - s ready=1; beats are consumed and discarded.
  - On last -> HDR.
- Output rules:
  - m data, keep and last are stable while m valid AND !m ready.
  - m valid never drops without a handshake.
- Latency for an accepted packet:
  - First output beat appears 1 cycle after the last header beat is accepted.
  - Throughput in PASS is 1 beat/cycle.
- Boundary conditions:
  - Header ending exactly at last (e.g. 512-bit single-beat 24..64 byte packet) is emitted as a 1-beat packet with last.
  - Header-decision cycle and a counter increment from another packet never coincide.
  - Counters wrap 0xFFFFFFFF -> 0 and still pulse.
  - Reset mid-packet: all state returns to reset values immediately.
  - Beats arriving after reset are treated as a new packet start; partial packets are not resynchronised.

Decomposition:
- davos_types.svh / shared package:
  - ROCE_UDP_PORT_DEFAULT, IPV4_PROTO_UDP=8'd17, IPV4_HDR_BYTES=20, UDP_DPORT_OFFSET=22.
  - State enum typedef {HDR, EMIT, PASS, DROP}.
- One sub-module, roce_rx_hdr_check: combinational accept/runt decision from the header buffer plus the current beat; parameterised on WIDTH.

Test Plan:
- WIDTH=512, local 10.1.0.5, single-beat 48-byte packet: version 4, IHL 5, proto 17, dst 10.1.0.5, port 4791 -> identical beat out 1 cycle later, last=1; both counters stay 0.
- WIDTH=64, 10-beat RoCE packet, m ready toggling 1/0 each cycle -> all 10 beats out in order, unchanged, stable while stalled; s ready=0 during EMIT.
- WIDTH=64, UDP port 4792, 6 beats -> no m valid; filter_drop_count=1, one pulse; the next valid RoCE packet passes intact.
- WIDTH=64, 2-beat packet with last on beat 1 -> no output; runt_drop_count=1.
- WIDTH=64, dst 10.1.0.6, then proto 6, then IHL 6 -> all three dropped; filter_drop_count=3.
- WIDTH=512, back-to-back RoCE packets, m ready=1 -> header of packet 2 collected while packet 1's last beat drains; no lost or duplicated beats; reset asserted mid-PASS -> m valid=0 the next cycle.
